// File: rtl/systolic_pkg.sv
// Shared types, default widths and product-extension helper for the systolic PE.
package systolic_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DRAIN = 2'd2
    } pe_state_t;

    localparam int unsigned DATA_W_DEF = 8;
    localparam int unsigned ACC_W_DEF  = 24;
    localparam int unsigned EXT_W      = 64;

    // Sign- or zero-extends a prod_w-bit product held in the low bits of prod.
    function automatic logic [EXT_W-1:0] extend_product(
        input logic [EXT_W-1:0] prod,
        input int unsigned      prod_w,
        input logic             is_signed
    );
        logic [EXT_W-1:0] keep;
        logic             msb;
        keep = (EXT_W'(1) << prod_w) - EXT_W'(1);
        msb  = |(prod & (EXT_W'(1) << (prod_w - 1)));
        if (is_signed && msb)
            return prod | ~keep;
        return prod & keep;
    endfunction

endpackage

// File: rtl/systolic_mac_unit.sv
// Combinational multiply, extend and accumulate for one PE.
// SYSTOLIC_PE_SAT_EN selects clamping accumulation and exposes the clamp indication.
module systolic_mac_unit
    import systolic_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned ACC_W  = ACC_W_DEF,
    parameter int unsigned SIGNED = 1
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [ACC_W-1:0]  acc,
    input  logic              clr,
    output logic [ACC_W-1:0]  sum
`ifdef SYSTOLIC_PE_SAT_EN
    ,
    output logic              sat
`endif
);

    logic [2*DATA_W-1:0] prod;
    logic [ACC_W-1:0]    base;
    logic [ACC_W-1:0]    addend;

    // Low 2*DATA_W bits of an unsigned multiply of pre-extended operands equal the signed product.
    always_comb begin
        if (SIGNED != 0)
            prod = {{DATA_W{a[DATA_W-1]}}, a} * {{DATA_W{b[DATA_W-1]}}, b};
        else
            prod = {{DATA_W{1'b0}}, a} * {{DATA_W{1'b0}}, b};
        addend = ACC_W'(extend_product(EXT_W'(prod), 2 * DATA_W, SIGNED != 0));
        base   = clr ? '0 : acc;
    end

`ifdef SYSTOLIC_PE_SAT_EN
    logic [ACC_W:0] wide;

    always_comb begin
        if (SIGNED != 0)
            wide = {base[ACC_W-1], base} + {addend[ACC_W-1], addend};
        else
            wide = {1'b0, base} + {1'b0, addend};
        sat = 1'b0;
        sum = wide[ACC_W-1:0];
        if (SIGNED != 0) begin
            if (wide[ACC_W] != wide[ACC_W-1]) begin
                sat = 1'b1;
                sum = wide[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
            end
        end else if (wide[ACC_W]) begin
            sat = 1'b1;
            sum = '1;
        end
    end
`else
    assign sum = base + addend;
`endif

endmodule

// File: rtl/systolic_mac_pe.sv
// Output-stationary systolic MAC processing element with double-buffered result chain.
// Optional SYSTOLIC_PE_SAT_EN: saturating accumulation plus sticky sat_flg output.
module systolic_mac_pe
    import systolic_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned ACC_W  = ACC_W_DEF,
    parameter int unsigned SIGNED = 1,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [DATA_W-1:0] a_in,
    input  logic              a_vld_in,
    input  logic [DATA_W-1:0] b_in,
    input  logic              b_vld_in,
    input  logic              acc_clr,
    input  logic              capture,
    input  logic              shift,
    input  logic [ACC_W-1:0]  c_in,
    input  logic              c_vld_in,
    output logic [DATA_W-1:0] a_out,
    output logic              a_vld_out,
    output logic [DATA_W-1:0] b_out,
    output logic              b_vld_out,
    output logic [ACC_W-1:0]  c_out,
    output logic              c_vld_out,
    output logic [CNT_W-1:0]  mac_cnt,
    output logic [1:0]        state
`ifdef SYSTOLIC_PE_SAT_EN
    ,
    output logic              sat_flg
`endif
);

    logic             mac;
    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] acc_next;
    pe_state_t        state_q;
    pe_state_t        state_d;

    assign mac   = a_vld_in & b_vld_in;
    assign state = state_q;

`ifdef SYSTOLIC_PE_SAT_EN
    logic sat_hit;
`endif

    systolic_mac_unit #(
        .DATA_W(DATA_W),
        .ACC_W (ACC_W),
        .SIGNED(SIGNED)
    ) u_mac (
        .a  (a_in),
        .b  (b_in),
        .acc(acc),
        .clr(acc_clr),
        .sum(acc_next)
`ifdef SYSTOLIC_PE_SAT_EN
        ,
        .sat(sat_hit)
`endif
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            a_out     <= '0;
            a_vld_out <= 1'b0;
            b_out     <= '0;
            b_vld_out <= 1'b0;
        end else begin
            a_out     <= a_in;
            a_vld_out <= a_vld_in;
            b_out     <= b_in;
            b_vld_out <= b_vld_in;
        end
    end

    // The mac unit already zeroes its base on acc_clr, so a MAC with clear yields the bare product.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            acc     <= '0;
            mac_cnt <= '0;
        end else begin
            if (mac)
                acc <= acc_next;
            else if (acc_clr)
                acc <= '0;

            if (acc_clr)
                mac_cnt <= mac ? CNT_W'(1) : '0;
            else if (mac && (mac_cnt != '1))
                mac_cnt <= mac_cnt + CNT_W'(1);
        end
    end

`ifdef SYSTOLIC_PE_SAT_EN
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            sat_flg <= 1'b0;
        else if (acc_clr)
            sat_flg <= 1'b0;
        else if (mac && sat_hit)
            sat_flg <= 1'b1;
    end
`endif

    // Capture reads acc before this cycle's update, giving the double-buffer handoff.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            c_out     <= '0;
            c_vld_out <= 1'b0;
        end else if (capture) begin
            c_out     <= acc;
            c_vld_out <= 1'b1;
        end else if (shift) begin
            c_out     <= c_in;
            c_vld_out <= c_vld_in;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (mac) state_d = ACCUM;
            ACCUM:   if (acc_clr && !mac) state_d = IDLE;
            DRAIN:   state_d = (mac_cnt != '0) ? ACCUM : IDLE;
            default: state_d = IDLE;
        endcase
        if (capture || shift)
            state_d = DRAIN;
    end

endmodule

// File: tb/tb_systolic_mac_pe.sv
// Self-checking bench: three differently-configured PEs against a behavioural model, plus a 3-PE chain.
module tb_systolic_mac_pe;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_err = 0;

    // Shared stimulus for the signed/24, unsigned/24 and signed/16 (CNT_W=4) PEs
    logic [7:0]  g_a = '0, g_b = '0;
    logic        g_av = 0, g_bv = 0, g_clr = 0, g_cap = 0, g_sh = 0, g_cv = 0;
    logic [23:0] g_cin = '0;

    logic [7:0]  fa [3];
    logic [7:0]  fb [3];
    logic        fav [3];
    logic        fbv [3];
    logic [23:0] s_c, u_c;
    logic [15:0] n_c;
    logic        ocv [3];
    logic [15:0] s_cnt, u_cnt;
    logic [3:0]  n_cnt;
    logic [1:0]  ost [3];
    logic [23:0] oc [3];
    logic [15:0] ocnt [3];

    assign oc[0] = s_c;
    assign oc[1] = u_c;
    assign oc[2] = {8'd0, n_c};
    assign ocnt[0] = s_cnt;
    assign ocnt[1] = u_cnt;
    assign ocnt[2] = {12'd0, n_cnt};

`ifdef SYSTOLIC_PE_SAT_EN
    logic s_sat, u_sat, n_sat;
    logic osat [3];
    assign osat[0] = s_sat;
    assign osat[1] = u_sat;
    assign osat[2] = n_sat;
`endif

    systolic_mac_pe #(.DATA_W(8), .ACC_W(24), .SIGNED(1), .CNT_W(16)) u_s (
        .clock(clock), .reset(reset), .a_in(g_a), .a_vld_in(g_av), .b_in(g_b), .b_vld_in(g_bv),
        .acc_clr(g_clr), .capture(g_cap), .shift(g_sh), .c_in(g_cin), .c_vld_in(g_cv),
        .a_out(fa[0]), .a_vld_out(fav[0]), .b_out(fb[0]), .b_vld_out(fbv[0]),
        .c_out(s_c), .c_vld_out(ocv[0]), .mac_cnt(s_cnt), .state(ost[0])
`ifdef SYSTOLIC_PE_SAT_EN
        , .sat_flg(s_sat)
`endif
    );

    systolic_mac_pe #(.DATA_W(8), .ACC_W(24), .SIGNED(0), .CNT_W(16)) u_u (
        .clock(clock), .reset(reset), .a_in(g_a), .a_vld_in(g_av), .b_in(g_b), .b_vld_in(g_bv),
        .acc_clr(g_clr), .capture(g_cap), .shift(g_sh), .c_in(g_cin), .c_vld_in(g_cv),
        .a_out(fa[1]), .a_vld_out(fav[1]), .b_out(fb[1]), .b_vld_out(fbv[1]),
        .c_out(u_c), .c_vld_out(ocv[1]), .mac_cnt(u_cnt), .state(ost[1])
`ifdef SYSTOLIC_PE_SAT_EN
        , .sat_flg(u_sat)
`endif
    );

    systolic_mac_pe #(.DATA_W(8), .ACC_W(16), .SIGNED(1), .CNT_W(4)) u_n (
        .clock(clock), .reset(reset), .a_in(g_a), .a_vld_in(g_av), .b_in(g_b), .b_vld_in(g_bv),
        .acc_clr(g_clr), .capture(g_cap), .shift(g_sh), .c_in(g_cin[15:0]), .c_vld_in(g_cv),
        .a_out(fa[2]), .a_vld_out(fav[2]), .b_out(fb[2]), .b_vld_out(fbv[2]),
        .c_out(n_c), .c_vld_out(ocv[2]), .mac_cnt(n_cnt), .state(ost[2])
`ifdef SYSTOLIC_PE_SAT_EN
        , .sat_flg(n_sat)
`endif
    );

    // Three-PE result chain: PE0 is the head, PE2 the tail
    logic [7:0]  ch_a [3];
    logic [7:0]  ch_b = 8'd1;
    logic        ch_v = 0, ch_clr = 0, ch_cap = 0, ch_sh = 0, ch_cvin = 0;
    logic [23:0] ch_cin = '0;
    logic [7:0]  ch_fa [3];
    logic [7:0]  ch_fb [3];
    logic        ch_fav [3];
    logic        ch_fbv [3];
    logic [23:0] ch_c [3];
    logic        ch_cv [3];
    logic [15:0] ch_cnt [3];
    logic [1:0]  ch_st [3];
`ifdef SYSTOLIC_PE_SAT_EN
    logic        ch_sat [3];
`endif

    for (genvar g = 0; g < 3; g++) begin : g_ch
        logic [23:0] cin;
        logic        cvin;
        if (g == 0) begin : g_head
            assign cin  = ch_cin;
            assign cvin = ch_cvin;
        end else begin : g_link
            assign cin  = ch_c[g-1];
            assign cvin = ch_cv[g-1];
        end
        systolic_mac_pe #(.DATA_W(8), .ACC_W(24), .SIGNED(1), .CNT_W(16)) u_pe (
            .clock(clock), .reset(reset), .a_in(ch_a[g]), .a_vld_in(ch_v), .b_in(ch_b), .b_vld_in(ch_v),
            .acc_clr(ch_clr), .capture(ch_cap), .shift(ch_sh), .c_in(cin), .c_vld_in(cvin),
            .a_out(ch_fa[g]), .a_vld_out(ch_fav[g]), .b_out(ch_fb[g]), .b_vld_out(ch_fbv[g]),
            .c_out(ch_c[g]), .c_vld_out(ch_cv[g]), .mac_cnt(ch_cnt[g]), .state(ch_st[g])
`ifdef SYSTOLIC_PE_SAT_EN
            , .sat_flg(ch_sat[g])
`endif
        );
    end

    // Behavioural model of the three shared-stimulus PEs, in plain integer arithmetic
    int     P_W [3]    = '{24, 24, 16};
    bit     P_S [3]    = '{1'b1, 1'b0, 1'b1};
    int     P_CMAX [3] = '{65535, 65535, 15};
    longint m_acc [3];
    longint m_c [3];
    bit     m_cv [3];
    int     m_cnt [3];
    int     m_st [3];
    bit     m_sat [3];
    logic [7:0] m_fa, m_fb;
    bit     m_fav, m_fbv;

    function automatic longint wrapv(input longint v, input longint md, input bit s);
        longint r;
        r = v % md;
        if (r < 0) r += md;
        if (s && r >= md / 2) r -= md;
        return r;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            m_acc[i] = 0; m_c[i] = 0; m_cv[i] = 0; m_cnt[i] = 0; m_st[i] = 0; m_sat[i] = 0;
        end
        m_fa = '0; m_fb = '0; m_fav = 0; m_fbv = 0;
    endtask

    task automatic tick();
        @(posedge clock);
        for (int i = 0; i < 3; i++) begin
            longint prod, s, md;
            bit mac, clamp;
            int ns;
            mac = g_av && g_bv;
            md  = longint'(1) << P_W[i];
            prod = P_S[i] ? longint'($signed(g_a)) * longint'($signed(g_b))
                          : longint'(g_a) * longint'(g_b);
            if (g_cap) begin
                m_c[i] = m_acc[i] & (md - 1); m_cv[i] = 1'b1;
            end else if (g_sh) begin
                m_c[i] = longint'(g_cin) & (md - 1); m_cv[i] = g_cv;
            end
            if (g_cap || g_sh) ns = 2;
            else if (m_st[i] == 0) ns = mac ? 1 : 0;
            else if (m_st[i] == 1) ns = (g_clr && !mac) ? 0 : 1;
            else ns = (m_cnt[i] != 0) ? 1 : 0;
            clamp = 1'b0;
            if (mac) begin
                s = (g_clr ? 0 : m_acc[i]) + prod;
`ifdef SYSTOLIC_PE_SAT_EN
                begin
                    longint lo, hi;
                    lo = P_S[i] ? -(md / 2) : 0;
                    hi = P_S[i] ? (md / 2 - 1) : (md - 1);
                    if (s > hi) begin s = hi; clamp = 1'b1; end
                    else if (s < lo) begin s = lo; clamp = 1'b1; end
                end
`else
                s = wrapv(s, md, P_S[i]);
`endif
                m_acc[i] = s;
            end else if (g_clr) begin
                m_acc[i] = 0;
            end
            if (g_clr) m_sat[i] = 1'b0;
            else if (clamp) m_sat[i] = 1'b1;
            if (g_clr) m_cnt[i] = mac ? 1 : 0;
            else if (mac && m_cnt[i] < P_CMAX[i]) m_cnt[i]++;
            m_st[i] = ns;
        end
        m_fa = g_a; m_fb = g_b; m_fav = g_av; m_fbv = g_bv;
        #1;
    endtask

    task automatic drive(input logic [7:0] a, input logic [7:0] b, input logic av, input logic bv,
                         input logic clr, input logic cap, input logic sh);
        g_a = a; g_b = b; g_av = av; g_bv = bv; g_clr = clr; g_cap = cap; g_sh = sh;
        g_cin = '0; g_cv = 1'b0;
    endtask

    task automatic test_reset();
        drive(8'd0, 8'd0, 0, 0, 0, 0, 0);
        model_reset();
        #12;
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (oc[i] !== 24'd0 || ocv[i] !== 1'b0 || ocnt[i] !== 16'd0 || ost[i] !== 2'd0 ||
                fa[i] !== 8'd0 || fav[i] !== 1'b0 || fb[i] !== 8'd0 || fbv[i] !== 1'b0) begin
                n_err++;
                $display("FAIL reset_pe%0d: got c=%0d cv=%0d cnt=%0d st=%0d a=%0d b=%0d required all 0",
                         i, oc[i], ocv[i], ocnt[i], ost[i], fa[i], fb[i]);
            end
            n_cmp++;
            if (ch_c[i] !== 24'd0 || ch_cv[i] !== 1'b0 || ch_st[i] !== 2'd0) begin
                n_err++;
                $display("FAIL reset_chain%0d: got c=%0d cv=%0d st=%0d required 0", i, ch_c[i], ch_cv[i], ch_st[i]);
            end
        end
        reset = 1'b1;
        @(posedge clock);
        #1;
    endtask

    task automatic test_signed_macs();
        drive(8'd0, 8'd0, 0, 0, 1, 0, 0); tick();
        drive(8'd3,   8'd5,   1, 1, 0, 0, 0); tick();
        drive(8'hFE,  8'd7,   1, 1, 0, 0, 0); tick();
        drive(8'd127, 8'd127, 1, 1, 0, 0, 0); tick();
        drive(8'h80,  8'h80,  1, 1, 0, 0, 0); tick();
        drive(8'd0, 8'd0, 0, 0, 0, 0, 0); tick();
        n_cmp++;
        if (s_cnt !== 16'd4) begin n_err++; $display("FAIL signed_cnt: got %0d required 4", s_cnt); end
        n_cmp++;
        if (ost[0] !== 2'd1) begin n_err++; $display("FAIL signed_state: got %0d required 1", ost[0]); end
        drive(8'd0, 8'd0, 0, 0, 0, 1, 0); tick();
        n_cmp++;
        if (s_c !== 24'd32514 || ocv[0] !== 1'b1) begin
            n_err++; $display("FAIL signed_acc: got %0d vld %0d required 32514 vld 1", s_c, ocv[0]);
        end
        n_cmp++;
        if (ost[0] !== 2'd2) begin n_err++; $display("FAIL signed_drain: got %0d required 2", ost[0]); end
    endtask

    task automatic test_unsigned_forward();
        drive(8'd255, 8'd255, 1, 1, 1, 0, 0); tick();
        drive(8'd255, 8'd255, 1, 1, 0, 0, 0); tick();
        drive(8'd255, 8'd255, 1, 1, 0, 0, 0); tick();
        drive(8'h5A, 8'hC3, 0, 1, 0, 0, 0);
        #1;
        n_cmp++;
        if (fa[1] !== 8'd255 || fav[1] !== 1'b1) begin
            n_err++; $display("FAIL fwd_early: got a=%0d v=%0d required 255 1", fa[1], fav[1]);
        end
        tick();
        n_cmp++;
        if (fa[1] !== 8'h5A || fav[1] !== 1'b0 || fb[1] !== 8'hC3 || fbv[1] !== 1'b1) begin
            n_err++; $display("FAIL fwd_latency: got a=%0h av=%0d b=%0h bv=%0d required 5a 0 c3 1",
                              fa[1], fav[1], fb[1], fbv[1]);
        end
        drive(8'd0, 8'd0, 0, 0, 0, 1, 0); tick();
        n_cmp++;
        if (u_c !== 24'd195075) begin n_err++; $display("FAIL unsigned_acc: got %0d required 195075", u_c); end
        n_cmp++;
        if (s_c !== 24'd3) begin n_err++; $display("FAIL signed_neg1_acc: got %0d required 3", s_c); end
    endtask

    task automatic test_handoff();
        drive(8'd10, 8'd10, 1, 1, 1, 0, 0); tick();
        drive(8'd2, 8'd3, 1, 1, 1, 1, 0); tick();
        n_cmp++;
        if (s_c !== 24'd100 || ocv[0] !== 1'b1) begin
            n_err++; $display("FAIL handoff_cap: got %0d vld %0d required 100 1", s_c, ocv[0]);
        end
        n_cmp++;
        if (s_cnt !== 16'd1) begin n_err++; $display("FAIL handoff_cnt: got %0d required 1", s_cnt); end
        drive(8'd0, 8'd0, 0, 0, 0, 1, 0); tick();
        n_cmp++;
        if (s_c !== 24'd6) begin n_err++; $display("FAIL handoff_new: got %0d required 6", s_c); end
    endtask

    task automatic test_chain();
        int exp_q[$];
        ch_a[0] = 8'd10; ch_a[1] = 8'd20; ch_a[2] = 8'd30;
        ch_v = 1'b1; ch_clr = 1'b1;
        @(posedge clock); #1;
        ch_v = 1'b0; ch_clr = 1'b0; ch_cap = 1'b1;
        @(posedge clock); #1;
        ch_cap = 1'b0;
        for (int i = 2; i >= 0; i--) exp_q.push_back(10 * (i + 1));
        ch_sh = 1'b1;
        for (int k = 0; k < 4; k++) begin
            if (exp_q.size() != 0) begin
                int e;
                e = exp_q.pop_front();
                n_cmp++;
                if (ch_c[2] !== 24'(e) || ch_cv[2] !== 1'b1) begin
                    n_err++; $display("FAIL chain_out%0d: got %0d vld %0d required %0d vld 1", k, ch_c[2], ch_cv[2], e);
                end
            end else begin
                n_cmp++;
                if (ch_cv[2] !== 1'b0) begin
                    n_err++; $display("FAIL chain_empty: got vld %0d required 0", ch_cv[2]);
                end
            end
            if (k < 3) begin @(posedge clock); #1; end
        end
        ch_sh = 1'b0;
    endtask

    task automatic test_reset_mid();
        drive(8'd20, 8'd25, 1, 1, 1, 0, 0); tick();
        drive(8'd0, 8'd0, 0, 0, 0, 1, 0); tick();
        n_cmp++;
        if (s_c !== 24'd500) begin n_err++; $display("FAIL pre_reset_acc: got %0d required 500", s_c); end
        drive(8'd1, 8'd1, 1, 1, 0, 0, 1);
        #2 reset = 1'b0;
        #1;
        n_cmp++;
        if (s_c !== 24'd0 || ocv[0] !== 1'b0 || ost[0] !== 2'd0 || s_cnt !== 16'd0 || fa[0] !== 8'd0 || fav[0] !== 1'b0) begin
            n_err++; $display("FAIL async_reset: got c=%0d cv=%0d st=%0d cnt=%0d a=%0d required all 0",
                              s_c, ocv[0], ost[0], s_cnt, fa[0]);
        end
        model_reset();
        drive(8'd0, 8'd0, 0, 0, 0, 0, 0);
        @(posedge clock);
        #2 reset = 1'b1;
        tick();
        drive(8'd3, 8'd4, 1, 1, 0, 0, 0); tick();
        drive(8'd0, 8'd0, 0, 0, 0, 1, 0); tick();
        n_cmp++;
        if (s_c !== 24'd12 || s_cnt !== 16'd1) begin
            n_err++; $display("FAIL post_reset_mac: got %0d cnt %0d required 12 cnt 1", s_c, s_cnt);
        end
    endtask

    task automatic test_overflow();
        drive(8'd0, 8'd0, 0, 0, 1, 0, 0); tick();
        for (int k = 0; k < 3; k++) begin drive(8'd127, 8'd127, 1, 1, 0, 0, 0); tick(); end
        drive(8'd0, 8'd0, 0, 0, 0, 1, 0); tick();
        n_cmp++;
        if (s_c !== 24'd48387) begin n_err++; $display("FAIL wide_no_ovf: got %0d required 48387", s_c); end
`ifdef SYSTOLIC_PE_SAT_EN
        n_cmp++;
        if (n_c !== 16'd32767 || n_sat !== 1'b1) begin
            n_err++; $display("FAIL sat_clamp: got %0d flg %0d required 32767 1", n_c, n_sat);
        end
        drive(8'd0, 8'd0, 0, 0, 1, 0, 0); tick();
        n_cmp++;
        if (n_sat !== 1'b0) begin n_err++; $display("FAIL sat_clear: got %0d required 0", n_sat); end
`else
        n_cmp++;
        if (n_c !== 16'd48387) begin n_err++; $display("FAIL wrap16: got %0d required 48387", n_c); end
`endif
    endtask

    task automatic test_cnt_saturate();
        drive(8'd0, 8'd0, 0, 0, 1, 0, 0); tick();
        for (int k = 0; k < 20; k++) begin drive(8'd1, 8'd1, 1, 1, 0, 0, 0); tick(); end
        n_cmp++;
        if (n_cnt !== 4'd15) begin n_err++; $display("FAIL cnt_sat: got %0d required 15", n_cnt); end
        n_cmp++;
        if (s_cnt !== 16'd20) begin n_err++; $display("FAIL cnt_20: got %0d required 20", s_cnt); end
    endtask

    task automatic test_random();
        for (int k = 0; k < 600; k++) begin
            drive(8'($urandom), 8'($urandom), $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                  $urandom_range(0, 15) == 0, $urandom_range(0, 7) == 0, $urandom_range(0, 5) == 0);
            g_cin = 24'($urandom);
            g_cv  = 1'($urandom);
            tick();
            for (int i = 0; i < 3; i++) begin
                n_cmp++;
                if (oc[i] !== 24'(m_c[i]) || ocv[i] !== m_cv[i]) begin
                    n_err++; $display("FAIL rnd_c pe%0d cyc%0d: got %0d/%0d required %0d/%0d", i, k, oc[i], ocv[i], m_c[i], m_cv[i]);
                end
                n_cmp++;
                if (ocnt[i] !== 16'(m_cnt[i]) || ost[i] !== 2'(m_st[i])) begin
                    n_err++; $display("FAIL rnd_cnt_st pe%0d cyc%0d: got %0d/%0d required %0d/%0d", i, k, ocnt[i], ost[i], m_cnt[i], m_st[i]);
                end
                n_cmp++;
                if (fa[i] !== m_fa || fb[i] !== m_fb || fav[i] !== m_fav || fbv[i] !== m_fbv) begin
                    n_err++; $display("FAIL rnd_fwd pe%0d cyc%0d: got %0h/%0h required %0h/%0h", i, k, fa[i], fb[i], m_fa, m_fb);
                end
`ifdef SYSTOLIC_PE_SAT_EN
                n_cmp++;
                if (osat[i] !== m_sat[i]) begin
                    n_err++; $display("FAIL rnd_sat pe%0d cyc%0d: got %0d required %0d", i, k, osat[i], m_sat[i]);
                end
`endif
            end
        end
    endtask

    initial begin
        ch_a[0] = '0; ch_a[1] = '0; ch_a[2] = '0;
        test_reset();
        test_signed_macs();
        test_unsigned_forward();
        test_handoff();
        test_chain();
        test_reset_mid();
        test_overflow();
        test_cnt_saturate();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/systolic_mac_pe.md
Name: systolic_mac_pe

Overview:
Parametrised output-stationary processing element for the systolic matrix-multiply array; successor to the 8-bit fixed-width PE.
- Forwards A east and B south with valid tags.
- Accumulates A×B into a wide, signed-or-unsigned accumulator.
- Offloads results through a shift chain, so a new tile can accumulate while the previous one drains (double-buffered).
- One instance per array cell; result chains run along rows to the array's edge collector.

Parameters:
DATA_W, 8, width of A/B operands
ACC_W, 24, accumulator and result width (must be ≥ 2*DATA_W)
SIGNED, 1, 1 = two's-complement operands, 0 = unsigned
CNT_W, 16, width of the MAC-count field

Ports:
clock  in  1  rising-edge clock
reset  in  1  asynchronous, active-low reset
a_in  in  DATA_W  operand from west neighbour
a_vld_in  in  1  a_in valid
b_in  in  DATA_W  operand from north neighbour
b_vld_in  in  1  b_in valid
acc_clr  in  1  start new tile; discard accumulator
capture  in  1  copy accumulator into result register
shift  in  1  shift result chain one position
c_in  in  ACC_W  result from upstream PE in chain
c_vld_in  in  1  c_in valid
a_out  out  DATA_W  registered a_in to east
a_vld_out  out  1  registered a_vld_in
b_out  out  DATA_W  registered b_in to south
b_vld_out  out  1  registered b_vld_in
c_out  out  ACC_W  result register to downstream PE
c_vld_out  out  1  result register holds valid data
mac_cnt  out  CNT_W  MACs performed since last clear
state  out  2  FSM state encoding

Behaviour:
Reset:
- All outputs and internal registers go to 0.
- state = IDLE.
- Reset is honoured mid-operation: accumulation and drain are discarded immediately.

Forwarding:
- a_out/a_vld_out and b_out/b_vld_out follow their inputs with exactly 1 cycle latency, unconditionally, in every state.

MAC:
- A MAC fires when a_vld_in && b_vld_in.
- Product is full 2*DATA_W, sign- or zero-extended to ACC_W per SIGNED.
- acc <= acc + product, wrapping modulo 2^ACC_W.
- Result is visible in acc the next cycle.

acc_clr:
- With a concurrent MAC: acc <= product, mac_cnt <= 1.
- Otherwise: acc <= 0, mac_cnt <= 0.

mac_cnt:
- Increments per MAC and saturates at all-ones; it never wraps.

FSM:
- IDLE -> ACCUM on the first MAC.
- ACCUM -> IDLE on acc_clr without a MAC.
- Any state -> DRAIN on capture or shift.
- DRAIN -> ACCUM when shift and capture are both low and mac_cnt != 0.
- DRAIN -> IDLE when shift and capture are both low and mac_cnt == 0.
- state encoding: IDLE=0, ACCUM=1, DRAIN=2.

Result chain:
- capture: c_out <= acc value before this cycle's update; c_vld_out <= 1.
- shift without capture: c_out <= c_in; c_vld_out <= c_vld_in.
- capture and shift together: capture wins.
- Neither: c_out and c_vld_out hold.

Simultaneous events:
- capture + acc_clr in the same cycle: the old acc is captured and the new tile starts. This is the intended double-buffer handoff.
- capture + MAC without acc_clr: the captured value excludes that cycle's product; acc still updates.

Optional Feature:
SYSTOLIC_PE_SAT_EN
- Defined: accumulation saturates to the ACC_W range (signed min/max when SIGNED=1, 0/all-ones when SIGNED=0).
- Defined: a sticky sat_flg output (1 bit) is added; it is set on any clamp and cleared by acc_clr or reset.
- Undefined: accumulation wraps and the sat_flg port does not exist.

Decomposition:
Shared package systolic_pkg holds:
- FSM state typedef/localparams: IDLE, ACCUM, DRAIN.
- Default width constants: DATA_W=8, ACC_W=24.
- Helper function for sign/zero extension of the product.

One sub-module, systolic_mac_unit, is natural:
- Contains the combinational multiply, extension, and add/saturate.
- PE keeps registers, FSM and chain.

Test Plan:
1. SIGNED=1, clear, then four MACs (3,5),(-2,7),(127,127),(-128,-128) -> acc = 15-14+16129+16384 = 32514; mac_cnt = 4; state = ACCUM.
2. SIGNED=0, a=255 b=255 three MACs -> acc = 195075; forwarded a_out/b_out appear exactly 1 cycle after input.
3. acc = 100, then capture + acc_clr together with MAC (2,3) -> c_out = 100, c_vld_out = 1; next cycle acc = 6, mac_cnt = 1.
4. Three-PE chain with captures 10, 20, 30, then shift held 3 cycles with c_in = 0, c_vld_in = 0 at the head -> tail c_out emits 30, 20, 10 then c_vld_out = 0.
5. Reset asserted mid-accumulation and mid-drain (acc = 500) -> all outputs 0 asynchronously; state = IDLE; first MAC after release starts from 0.
6. SAT_EN, SIGNED=1, ACC_W=16, repeated (127,127) ×3 -> acc clamps at 32767, sat_flg = 1; without SAT_EN acc wraps to 48387 - 65536 = -17149.
